// File: rtl/regfile_wb.sv
// regfile_wb: 32 x 8-bit register file with a 2-entry write-request FIFO and
// a drain-then-clear sequence that zeroes every register.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset
//   wb_valid  write request valid
//   wb_ready  request can be accepted this cycle
//   wb_sel    destination register (0-31 stored, 32-63 discarded)
//   wb_data   write data
//   clr_req   single-cycle pulse requesting a zero-clear of all registers
//   clr_busy  drain/clear sequence in progress
//   regfile   flattened storage, register i at [8i+7:8i]
//   pending   bit i set while a queued request targets register i
//   drop_cnt  saturating count of discarded writes
module regfile_wb (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [5:0]   wb_sel,
  input  logic [7:0]   wb_data,
  input  logic         clr_req,
  output logic         clr_busy,
  output logic [255:0] regfile,
  output logic [31:0]  pending,
  output logic [7:0]   drop_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] mem_q [32];
  logic [7:0] mem_d [32];
  // FIFO kept as a shift register: slot 0 is always the head.
  logic [5:0] sel_q  [2];
  logic [5:0] sel_d  [2];
  logic [7:0] data_q [2];
  logic [7:0] data_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] drop_q, drop_d;

  logic accept;
  logic pop;
  logic slot;

  assign wb_ready = rst_n && (state_q == StIdle) && (cnt_q < 2'd2);
  assign clr_busy = rst_n && (state_q != StIdle);
  assign drop_cnt = drop_q;
  assign accept   = wb_valid && wb_ready;
  assign pop      = (state_q != StClear) && (cnt_q != 2'd0);
  // Incoming entry lands behind whatever remains after this cycle's pop.
  assign slot     = (cnt_q == 2'd1) && !pop;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q + {1'b0, accept} - {1'b0, pop};
    idx_d   = idx_q;
    drop_d  = drop_q;

    if (pop) begin
      if (!sel_q[0][5]) begin
        mem_d[sel_q[0][4:0]] = data_q[0];
      end else if (drop_q != 8'hff) begin
        drop_d = drop_q + 8'd1;
      end
      sel_d[0]  = sel_q[1];
      data_d[0] = data_q[1];
    end

    if (accept) begin
      sel_d[slot]  = wb_sel;
      data_d[slot] = wb_data;
    end

    case (state_q)
      StIdle: begin
        if (clr_req) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == 2'd0) begin
          state_d = StClear;
          idx_d   = 5'd0;
        end
      end
      StClear: begin
        mem_d[idx_q] = 8'h00;
        if (idx_q == 5'd31) begin
          state_d = StIdle;
          idx_d   = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h00;
      for (int i = 0; i < 2; i++) begin
        sel_q[i]  <= 6'd0;
        data_q[i] <= 8'h00;
      end
      cnt_q  <= 2'd0;
      idx_q  <= 5'd0;
      drop_q <= 8'h00;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) regfile[8*i +: 8] = mem_q[i];
  end

  always_comb begin
    pending = '0;
    if (rst_n) begin
      if ((cnt_q != 2'd0) && !sel_q[0][5]) pending[sel_q[0][4:0]] = 1'b1;
      if ((cnt_q == 2'd2) && !sel_q[1][5]) pending[sel_q[1][4:0]] = 1'b1;
    end
  end

endmodule
